// File: rtl/vec_stream_feeder_pkg.sv
// Shared definitions for the vector stream feeder.
//   - lane/word geometry
//   - packed FIFO entry layout {last, a, b}
//   - issue FSM state encoding
//   - lane_put(): write one byte lane into a packed word
package vec_stream_feeder_pkg;

  localparam int LANE_W    = 8;
  localparam int WORD_W    = 32;
  localparam int MAX_LANES = 4;

  // FIFO entry: {last, a[31:0], b[31:0]}
  localparam int ENT_W    = 2 * WORD_W + 1;
  localparam int LAST_BIT = 2 * WORD_W;
  localparam int A_LSB    = WORD_W;
  localparam int B_LSB    = 0;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } vec_ent_t;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_WAIT  = 1'b1
  } iss_state_e;

  function automatic logic [WORD_W-1:0] lane_put(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        idx,
    input logic [LANE_W-1:0] v
  );
    logic [WORD_W-1:0] r;
    r = w;
    r[idx*LANE_W +: LANE_W] = v;
    return r;
  endfunction

endpackage

// File: rtl/vec_word_fifo.sv
// Synchronous first-word-fall-through FIFO for packed vector words.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_push, i_wdata   write strobe and data (caller never pushes when full)
//   i_pop             read strobe (caller never pops when empty)
//   o_rdata           head entry, valid whenever o_empty is low
//   o_full, o_empty   occupancy flags
//   o_level           current occupancy, 0..DEPTH
module vec_word_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LW-1:0]    r_level;

  // Storage carries no reset; only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (i_pop)  r_rp <= r_rp + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rp];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/vec_stream_feeder.sv
// Vector stream feeder: packs LANES int8 operand pairs per beat into
// 32-bit vec_a/vec_b words, segments the stream into ELEMS-element
// vectors (zero-padding the final beat), buffers words in a FIFO and
// issues them as single-cycle vec_valid beats at least GAP+1 cycles apart.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      operand pair handshake
//   in_a, in_b             operand bytes
//   vec_valid              one-cycle beat strobe
//   vec_a, vec_b           packed beat, lane i at [i*8+:8]; held between beats
//   vec_last               final beat of a vector (qualified by vec_valid)
//   busy                   partial word/vector, FIFO content or gap pending
//   fifo_level             FIFO occupancy
module vec_stream_feeder
  import vec_stream_feeder_pkg::*;
#(
  parameter  int ELEMS      = 1000,
  parameter  int LANES      = 1,
  parameter  int FIFO_DEPTH = 8,
  parameter  int GAP        = 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_a,
  input  logic [LANE_W-1:0] in_b,
  output logic              vec_valid,
  output logic [WORD_W-1:0] vec_a,
  output logic [WORD_W-1:0] vec_b,
  output logic              vec_last,
  output logic              busy,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int EW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int GW = $clog2(GAP + 2);

  // ---------------- packer ----------------
  logic [1:0]        r_lane;
  logic [EW-1:0]     r_elem_cnt;
  logic [WORD_W-1:0] r_stg_a;
  logic [WORD_W-1:0] r_stg_b;

  logic              w_acc;
  logic              w_elast;
  logic              w_push;
  logic [WORD_W-1:0] w_mrg_a;
  logic [WORD_W-1:0] w_mrg_b;
  vec_ent_t          w_wr;

  // FIFO side
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  vec_ent_t          w_rd;
  logic [LVL_W-1:0]  w_level;

  assign in_ready = !w_full;
  assign w_acc    = in_valid && in_ready;
  assign w_elast  = (r_elem_cnt == EW'(ELEMS - 1));
  // A word closes on a full lane set or on the vector's last element,
  // which leaves the upper lanes of a short final beat at zero.
  assign w_push   = w_acc && ((r_lane == 2'(LANES - 1)) || w_elast);
  assign w_mrg_a  = lane_put(r_stg_a, r_lane, in_a);
  assign w_mrg_b  = lane_put(r_stg_b, r_lane, in_b);

  always_comb begin
    w_wr      = '0;
    w_wr.last = w_elast;
    w_wr.a    = w_mrg_a;
    w_wr.b    = w_mrg_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lane     <= '0;
      r_elem_cnt <= '0;
      r_stg_a    <= '0;
      r_stg_b    <= '0;
    end else if (w_acc) begin
      r_elem_cnt <= w_elast ? '0 : r_elem_cnt + EW'(1);
      if (w_push) begin
        r_lane  <= '0;
        r_stg_a <= '0;
        r_stg_b <= '0;
      end else begin
        r_lane  <= r_lane + 2'(1);
        r_stg_a <= w_mrg_a;
        r_stg_b <= w_mrg_b;
      end
    end
  end

  vec_word_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wr),
    .i_pop   (w_pop),
    .o_rdata (w_rd),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign fifo_level = w_level;

  // ---------------- issue FSM ----------------
  iss_state_e        r_state;
  iss_state_e        w_nxt;
  logic [GW-1:0]     r_gap_cnt;
  logic              r_vec_valid;
  logic              r_vec_last;
  logic [WORD_W-1:0] r_vec_a;
  logic [WORD_W-1:0] r_vec_b;

  always_comb begin
    w_nxt = r_state;
    w_pop = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          // GAP=0 stays in ISSUE for back-to-back beats.
          if (GAP != 0) w_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_gap_cnt == GW'(1)) w_nxt = ST_ISSUE;
      end
      default: w_nxt = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ISSUE;
      r_gap_cnt   <= '0;
      r_vec_valid <= 1'b0;
      r_vec_last  <= 1'b0;
      r_vec_a     <= '0;
      r_vec_b     <= '0;
    end else begin
      r_state     <= w_nxt;
      r_vec_valid <= w_pop;
      r_vec_last  <= w_pop && w_rd.last;
      if (w_pop) begin
        r_gap_cnt <= GW'(GAP);
        r_vec_a   <= w_rd.a;
        r_vec_b   <= w_rd.b;
      end else if (r_state == ST_WAIT) begin
        r_gap_cnt <= r_gap_cnt - GW'(1);
      end
    end
  end

  assign vec_valid = r_vec_valid;
  assign vec_last  = r_vec_last;
  assign vec_a     = r_vec_a;
  assign vec_b     = r_vec_b;

  assign busy = (r_lane != '0) || (r_elem_cnt != '0) || (w_level != '0) ||
                (r_state == ST_WAIT) || r_vec_valid;

endmodule

// File: tb/tb_vec_stream_feeder.sv
module tb_vec_stream_feeder;

  // Two configurations side by side on shared inputs:
  //   d0: LANES=4, ELEMS=6, DEPTH=4, GAP=3  (padding, backpressure, gaps)
  //   d1: LANES=1, ELEMS=3, DEPTH=2, GAP=0  (single lane, back-to-back, wrap)
  localparam int PL[2] = '{4, 1};
  localparam int PE[2] = '{6, 3};
  localparam int PD[2] = '{4, 2};
  localparam int PG[2] = '{3, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_a, in_b;

  logic        rdy[2], vv[2], vl[2], bz[2];
  logic [31:0] va[2], vb[2];
  logic [2:0]  lv0;
  logic [1:0]  lv1;
  int          lvl[2];

  always #5 clk = ~clk;

  vec_stream_feeder #(.ELEMS(PE[0]), .LANES(PL[0]), .FIFO_DEPTH(PD[0]), .GAP(PG[0])) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .vec_valid(vv[0]), .vec_a(va[0]), .vec_b(vb[0]),
    .vec_last(vl[0]), .busy(bz[0]), .fifo_level(lv0));

  vec_stream_feeder #(.ELEMS(PE[1]), .LANES(PL[1]), .FIFO_DEPTH(PD[1]), .GAP(PG[1])) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .vec_valid(vv[1]), .vec_a(va[1]), .vec_b(vb[1]),
    .vec_last(vl[1]), .busy(bz[1]), .fifo_level(lv1));

  always_comb begin
    lvl[0] = int'(lv0);
    lvl[1] = int'(lv1);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Words are formed from the accepted element stream; a beat issues at
  // the earliest edge where a word is waiting and at least GAP+1 edges
  // have passed since the previous beat.
  int          ecnt = 0;
  bit          started = 0;
  int          pushed[2], popped[2], last_e[2], epos[2], nb[2];
  logic [7:0]  ba[2][4], bb[2][4];
  logic [64:0] wmem[2][8192];
  logic        exp_v[2], exp_l[2];
  logic [31:0] ha[2], hb[2];
  logic [31:0] m_wa, m_wb;

  always @(posedge clk) begin
    ecnt++;
    started = 1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pushed[d] = 0; popped[d] = 0; last_e[d] = -1000;
        epos[d] = 0; nb[d] = 0;
        exp_v[d] = 0; exp_l[d] = 0; ha[d] = 0; hb[d] = 0;
      end else begin
        exp_v[d] = 0; exp_l[d] = 0;
        if ((ecnt - last_e[d] >= PG[d] + 1) && (pushed[d] > popped[d])) begin
          {exp_l[d], ha[d], hb[d]} = wmem[d][popped[d] % 8192];
          popped[d]++;
          last_e[d] = ecnt;
          exp_v[d]  = 1;
        end
        if (in_valid && rdy[d]) begin
          ba[d][nb[d]] = in_a;
          bb[d][nb[d]] = in_b;
          nb[d]++;
          epos[d]++;
          if (nb[d] == PL[d] || epos[d] == PE[d]) begin
            m_wa = 0; m_wb = 0;
            for (int i = 0; i < nb[d]; i++) begin
              m_wa[i*8 +: 8] = ba[d][i];
              m_wb[i*8 +: 8] = bb[d][i];
            end
            wmem[d][pushed[d] % 8192] = {(epos[d] == PE[d]), m_wa, m_wb};
            pushed[d]++;
            nb[d] = 0;
            if (epos[d] == PE[d]) epos[d] = 0;
          end
        end
      end
    end
  end

  // ---------------- compare process + beat log ----------------
  int          nbeat[2] = '{0, 0};
  logic [31:0] log_a[2][8192], log_b[2][8192];
  logic        log_l[2][8192];
  int          log_t[2][8192];

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        int  lx;
        bit  bx;
        lx = pushed[d] - popped[d];
        bx = (epos[d] != 0) || (lx != 0) ||
             (ecnt - last_e[d] < ((PG[d] > 0) ? PG[d] : 1));
        check($sformatf("d%0d vec_valid", d), vv[d], exp_v[d]);
        check($sformatf("d%0d vec_last", d), vl[d], exp_v[d] ? exp_l[d] : 1'b0);
        check($sformatf("d%0d vec_a", d), va[d], ha[d]);
        check($sformatf("d%0d vec_b", d), vb[d], hb[d]);
        check($sformatf("d%0d fifo_level", d), lvl[d], lx);
        check($sformatf("d%0d in_ready", d), rdy[d], (lx != PD[d]));
        check($sformatf("d%0d busy", d), bz[d], bx);
        if (vv[d]) begin
          log_a[d][nbeat[d] % 8192] = va[d];
          log_b[d][nbeat[d] % 8192] = vb[d];
          log_l[d][nbeat[d] % 8192] = vl[d];
          log_t[d][nbeat[d] % 8192] = ecnt;
          nbeat[d]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d vec_valid", tag, d), vv[d], 1'b0);
      check($sformatf("%s d%0d vec_a", tag, d), va[d], 32'h0);
      check($sformatf("%s d%0d vec_last", tag, d), vl[d], 1'b0);
      check($sformatf("%s d%0d fifo_level", tag, d), lvl[d], 0);
      check($sformatf("%s d%0d busy", tag, d), bz[d], 1'b0);
      check($sformatf("%s d%0d in_ready", tag, d), rdy[d], 1'b1);
    end
  endtask

  int b0, b1;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h0; in_b = 8'h0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst");
    rst_n = 1'b1;

    // Directed: a=01..06, b=11..16
    b0 = nbeat[0]; b1 = nbeat[1];
    for (int k = 0; k < 6; k++) send(8'(k + 1), 8'(8'h11 + k));
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("dir d0 beats", nbeat[0] - b0, 2);
    check("dir d0 beat0 a", log_a[0][b0], 32'h04030201);
    check("dir d0 beat0 b", log_b[0][b0], 32'h14131211);
    check("dir d0 beat0 last", log_l[0][b0], 1'b0);
    check("dir d0 beat1 a", log_a[0][b0+1], 32'h00000605);
    check("dir d0 beat1 b", log_b[0][b0+1], 32'h00001615);
    check("dir d0 beat1 last", log_l[0][b0+1], 1'b1);
    check("dir d0 spacing", log_t[0][b0+1] - log_t[0][b0], 4);
    check("dir d1 beats", nbeat[1] - b1, 6);
    check("dir d1 beat2 last", log_l[1][b1+2], 1'b1);
    check("dir d1 beat1 last", log_l[1][b1+1], 1'b0);
    check("dir d1 beat5 a", log_a[1][b1+5], 32'h00000006);
    check("dir d1 beat5 b", log_b[1][b1+5], 32'h00000016);
    check("dir d1 beat5 last", log_l[1][b1+5], 1'b1);
    check("dir d1 back2back", log_t[1][b1+5] - log_t[1][b1], 5);
    check("dir d0 idle", bz[0], 1'b0);
    check("dir d1 idle", bz[1], 1'b0);

    // Reset in the middle of a vector discards the partial data.
    send(8'h41, 8'h51);
    send(8'h42, 8'h52);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    #1 check_reset_outputs("midrst");
    rst_n = 1'b1;
    b0 = nbeat[0]; b1 = nbeat[1];
    for (int k = 0; k < 6; k++) send(8'(8'h21 + k), 8'(8'h31 + k));
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("post d0 beats", nbeat[0] - b0, 2);
    check("post d0 beat0 a", log_a[0][b0], 32'h24232221);
    check("post d0 beat1 a", log_a[0][b0+1], 32'h00002625);
    check("post d0 beat1 last", log_l[0][b0+1], 1'b1);
    check("post d1 beat0 a", log_a[1][b1], 32'h00000021);
    check("post d1 beat2 last", log_l[1][b1+2], 1'b1);

    // Random traffic with one mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 4) != 0);
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      rst_n = (i != 1500);
      @(negedge clk);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    repeat (100) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_stream_feeder.md
Name: vec_stream_feeder

Overview:
Upstream stage of vector_mac_top_param. It accepts one int8 operand pair per cycle over a valid/ready interface and packs LANES pairs into 32-bit vec_a/vec_b words. Packed words are buffered in a small FIFO and issued as single-cycle vec_valid beats with a programmable idle gap. It segments the stream into vectors of ELEMS elements, zero-padding the final beat of each vector.

Parameters:
ELEMS, 1000, elements per vector; must match the MAC's ELEMS
LANES, 1, lanes per beat; legal values 1 or 4; must match the MAC's ACTIVE_LANES
FIFO_DEPTH, 8, packed-word FIFO entries; power of 2, at least 2
GAP, 1, minimum idle cycles between vec_valid pulses; 0 means back-to-back

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair present
in_ready  out  1  feeder can accept a pair this cycle
in_a  in  8  operand A element, unsigned
in_b  in  8  operand B element, unsigned
vec_valid  out  1  single-cycle beat strobe to the MAC
vec_a  out  32  packed A; lane i at bits [i*8+:8]
vec_b  out  32  packed B; same packing as vec_a
vec_last  out  1  high with vec_valid on the final beat of a vector
busy  out  1  partial word, FIFO content or gap pending
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values: vec_valid=0, vec_a=0, vec_b=0, vec_last=0, fifo_level=0, busy=0. in_ready=1 in the first cycle after reset.
- Accept: a pair is accepted when in_valid && in_ready. in_ready = (fifo_level != FIFO_DEPTH). in_ready is purely count-based; a pop in the same cycle does not raise it.
- Packer state: lane_idx (0..LANES-1), elem_cnt (0..ELEMS-1), staging registers stg_a/stg_b.
- On accept, the incoming byte goes to lane lane_idx.
- Push condition: a push occurs in the same cycle as an accept when lane_idx==LANES-1 or elem_cnt==ELEMS-1.
- Push data: the FIFO write is stg with the new byte merged, unused lanes zero, and last=(elem_cnt==ELEMS-1).
- After a push: staging clears to 0 and lane_idx returns to 0.
- elem_cnt increments on every accept and wraps from ELEMS-1 to 0. No idle cycle is inserted between vectors.
- Beats per vector = ceil(ELEMS/LANES). For ELEMS=1000 this is 1000 beats at LANES=1 and 250 at LANES=4.
- With LANES=1, bits [31:8] of vec_a/vec_b are always 0.
- FIFO entry format: {last, a[31:0], b[31:0]}, 65 bits. It is a first-word-fall-through read.
- Simultaneous push and pop leaves fifo_level unchanged.
- Issue FSM, state ISSUE: the entry state; it waits for a nonempty FIFO. If nonempty, at the next edge it pops and registers vec_a/vec_b/vec_last, drives vec_valid=1 for exactly one cycle, loads gap_cnt=GAP, and goes to WAIT (or stays in ISSUE if GAP=0).
- Issue FSM, state WAIT: gap_cnt decrements each cycle with vec_valid=0. When gap_cnt reaches 1 it moves to ISSUE.
- Issue spacing: with GAP=g, consecutive vec_valid pulses are at least g+1 cycles apart.
- Latency: a word pushed at edge k, into an empty FIFO with the FSM in ISSUE, gives vec_valid high in the cycle after edge k+1.
- Output hold: vec_a/vec_b hold the last issued beat between pulses. vec_last is only meaningful while vec_valid=1; it is registered 0 otherwise.
- busy = (lane_idx!=0) || (elem_cnt!=0) || (fifo_level!=0) || (state==WAIT) || vec_valid.
- Reset mid-operation: all counters, the FIFO, staging, FSM and outputs return to reset values; the partial vector is discarded. The MAC shares rst_n, so both restart aligned.
- Overflow cannot occur; no underflow pop ever happens. Values of in_a/in_b while in_valid=0 are ignored.

Decomposition:
- Shared header vecmac_defs.vh, holding:
  - LANE_W=8, WORD_W=32, MAX_LANES=4
  - FIFO entry width 2*WORD_W+1 and field offsets (LAST_BIT, A_LSB, B_LSB)
  - issue FSM state encodings ST_ISSUE, ST_WAIT
- Sub-module vec_word_fifo: parameterised synchronous FIFO (WIDTH, DEPTH) with push, pop, full, empty and level, synchronous active-low reset. It is instantiated once.
- The packer and issue FSM stay in vec_stream_feeder.

Test Plan:
1. LANES=1, ELEMS=4, GAP=1; send continuous pairs a=01,02,03,04 and b=05,06,07,08 -> 4 vec_valid pulses 2 cycles apart with vec_a=0x00000001..0x00000004 and vec_b=0x00000005..0x00000008; vec_last only on the 4th; busy falls after the last pulse.
2. LANES=4, ELEMS=6, GAP=1; send a=01..06, b=11..16 -> beat0 vec_a=0x04030201, vec_b=0x14131211, vec_last=0; beat1 vec_a=0x00000605, vec_b=0x00001615, vec_last=1.
3. LANES=1, FIFO_DEPTH=4, GAP=3; send 12 pairs back-to-back -> in_ready drops whenever fifo_level=4; fifo_level never exceeds 4; all 12 beats issued in order with no loss or duplication; pulse spacing is at least 4 cycles.
4. ELEMS=3, LANES=1, GAP=0; send 6 pairs back-to-back -> 6 consecutive-cycle vec_valid pulses with vec_last on beats 3 and 6, confirming elem_cnt wrap.
5. LANES=4, ELEMS=8; send 2 pairs, then rst_n=0 for 1 cycle -> all outputs at reset values and fifo_level=0; the next 8 pairs produce exactly 2 beats with vec_last on the 2nd and no residue from the discarded data.
6. Integration with vector_mac_top_param, ELEMS=1000, LANES=4 and LANES=1, GAP=1, 1000 random pairs -> 250 (resp. 1000) beats; result_valid fires once with result_sum equal to the golden sum of a*b.
